// File: rtl/conv1d_bram_engine_if.sv
// Sample-memory read port and result stream of the conv1d engine.
// The master side is the engine, the slave side is the memory and consumer.
interface conv1d_bram_engine_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int ACC_WIDTH  = 16
);
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_rd_en;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  out_valid;
    logic                  out_ready;
    logic [ACC_WIDTH-1:0]  out_data;

    modport master (
        output mem_addr, mem_rd_en, out_valid, out_data,
        input  mem_rdata, out_ready
    );
    modport slave (
        input  mem_addr, mem_rd_en, out_valid, out_data,
        output mem_rdata, out_ready
    );
endinterface

// File: rtl/conv1d_bram_engine.sv
// Streams N samples from a 1-cycle-latency memory through a K-tap window and emits strided dot products.
// First result K+2 cycles after start; out_ready backpressure halts reads, one-entry skid absorbs the in-flight sample.
module conv1d_bram_engine #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int K          = 3,
    parameter int ACC_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [ADDR_WIDTH:0]     len,
    input  logic [1:0]              stride,
    input  logic [K*DATA_WIDTH-1:0] weights,
    output logic                    busy,
    output logic                    done,
    conv1d_bram_engine_if.master    bus
);
    localparam int CW = ADDR_WIDTH + 2;
    localparam logic [ADDR_WIDTH:0] K_LEN = (ADDR_WIDTH+1)'(K);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;
    state_t state, state_nxt;

    logic [ADDR_WIDTH:0]   len_q;
    logic [1:0]            stride_q;
    logic [DATA_WIDTH-1:0] w_q     [K];
    logic [DATA_WIDTH-1:0] win     [K];
    logic [DATA_WIDTH-1:0] win_nxt [K];
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic                  rvld;
    logic [CW-1:0]         smp_idx;
    logic [CW-1:0]         next_res;
    logic                  out_vld_q, out_last_q, skid_vld, skid_last, done_q, last_seen;
    logic [ACC_WIDTH-1:0]  out_q, skid_q, res_sum;
    logic                  rd_go, xfer, res_vld, res_last, last_xfer, fin;

    // Window after the arriving sample shifts in; the sum is taken on that view
    always_comb begin
        for (int i = 0; i < K-1; i++) win_nxt[i] = win[i+1];
        win_nxt[K-1] = bus.mem_rdata;
        res_sum = '0;
        for (int i = 0; i < K; i++)
            res_sum = res_sum + ACC_WIDTH'((2*DATA_WIDTH)'(w_q[i]) * (2*DATA_WIDTH)'(win_nxt[i]));
    end

    assign res_vld  = rvld && (smp_idx == next_res);
    assign res_last = (smp_idx + CW'(stride_q)) >= CW'(len_q);
    assign xfer     = out_vld_q && bus.out_ready;
    assign last_xfer = xfer && out_last_q;

    always_comb begin
        state_nxt = state;
        rd_go     = 1'b0;
        fin       = 1'b0;
        case (state)
            IDLE:  if (start && len >= K_LEN) state_nxt = RUN;
            RUN: begin
                rd_go = !(out_vld_q && !bus.out_ready) && !skid_vld;
                if (rd_go && rd_ptr == ADDR_WIDTH'(len_q - (ADDR_WIDTH+1)'(1)))
                    state_nxt = FLUSH;
            end
            FLUSH: begin
                // a large stride can deliver the final result before the last read is issued
                fin = last_xfer || last_seen;
                if (fin) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy          = (state != IDLE);
    assign done          = done_q || fin;
    assign bus.mem_rd_en = rd_go;
    assign bus.mem_addr  = rd_ptr;
    assign bus.out_valid = out_vld_q;
    assign bus.out_data  = out_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q      <= '0;
            stride_q   <= 2'd1;
            for (int i = 0; i < K; i++) begin
                w_q[i] <= '0;
                win[i] <= '0;
            end
            rd_ptr     <= '0;
            rvld       <= 1'b0;
            smp_idx    <= '0;
            next_res   <= '0;
            out_vld_q  <= 1'b0;
            out_last_q <= 1'b0;
            out_q      <= '0;
            skid_vld   <= 1'b0;
            skid_last  <= 1'b0;
            skid_q     <= '0;
            done_q     <= 1'b0;
            last_seen  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state == IDLE && start) begin
                len_q     <= len;
                stride_q  <= (stride == 2'd0) ? 2'd1 : stride;
                for (int i = 0; i < K; i++) w_q[i] <= weights[i*DATA_WIDTH +: DATA_WIDTH];
                rd_ptr    <= '0;
                smp_idx   <= '0;
                next_res  <= CW'(K-1);
                last_seen <= 1'b0;
                done_q    <= (len < K_LEN);
            end
            if (rd_go) rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
            if (state == RUN && last_xfer) last_seen <= 1'b1;
            rvld <= rd_go;
            if (rvld) begin
                win     <= win_nxt;
                smp_idx <= smp_idx + CW'(1);
                if (res_vld) next_res <= next_res + CW'(stride_q);
            end
            if (xfer || !out_vld_q) begin
                if (skid_vld) begin
                    out_vld_q  <= 1'b1;
                    out_q      <= skid_q;
                    out_last_q <= skid_last;
                    skid_vld   <= res_vld;
                    skid_q     <= res_sum;
                    skid_last  <= res_last;
                end else begin
                    out_vld_q <= res_vld;
                    if (res_vld) begin
                        out_q      <= res_sum;
                        out_last_q <= res_last;
                    end
                end
            end else if (res_vld) begin
                // reads stop once the output stalls, so the skid is empty here
                skid_vld  <= 1'b1;
                skid_q    <= res_sum;
                skid_last <= res_last;
            end
        end
    end
endmodule

// File: doc/conv1d_bram_engine.md
CONV1D_BRAM_ENGINE -- requirements
Module: conv1d_bram_engine

Interface
REQ-001 Parameter DATA_WIDTH, default 8: width of input samples and weights, unsigned.
REQ-002 Parameter ADDR_WIDTH, default 4: sample-memory address width.
REQ-003 Parameter K, default 3: kernel taps, legal range 2..8.
REQ-004 Parameter ACC_WIDTH, default 16: result width.
REQ-005 clk  in  1  single clock; all state updates on its rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 start  in  1  job request; sampled only in IDLE.
REQ-008 len  in  ADDR_WIDTH+1  number of input samples N, 0..2^ADDR_WIDTH.
REQ-009 stride  in  2  output stride; value 0 treated as 1.
REQ-010 weights  in  K*DATA_WIDTH  tap i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-011 mem_addr  out  ADDR_WIDTH  sample-memory read address.
REQ-012 mem_rd_en  out  1  read strobe.
REQ-013 mem_rdata  in  DATA_WIDTH  read data, valid exactly one cycle after mem_rd_en.
REQ-014 out_valid  out  1 / out_ready  in  1 / out_data  out  ACC_WIDTH: result stream handshake.
REQ-015 busy  out  1  job in progress; done  out  1  one-cycle job-complete pulse.

Function
REQ-016 FSM states IDLE, RUN, FLUSH; IDLE->RUN on start when len>=K; IDLE stays IDLE and pulses done next cycle when start and len<K (zero results).
REQ-017 On accepted start, len, stride and weights are latched; later changes have no effect on the job.
REQ-018 RUN issues reads at addresses 0..N-1 in order, at most one per cycle; RUN->FLUSH after address N-1 issued.
REQ-019 Each returned sample shifts into a K-deep window; window slot 0 holds the oldest sample.
REQ-020 Result j = sum over i of weights[i]*x[j*stride+i], j = 0..M-1, M = floor((N-K)/stride)+1; computed only when the window holds x[j*stride..j*stride+K-1].
REQ-021 Products are full 2*DATA_WIDTH width; the sum is truncated modulo 2^ACC_WIDTH.
REQ-022 Results are presented in index order; none dropped, duplicated or reordered.
REQ-023 Transfer occurs when out_valid and out_ready are both 1; out_data stable while out_valid=1 and out_ready=0.
REQ-024 mem_rd_en deasserted in any cycle where out_valid=1 and out_ready=0, or the skid register is full.
REQ-025 A sample returned while stalled is still shifted in; a result it completes is held in a one-entry skid register and presented next.
REQ-026 Stride-1, out_ready=1 latency: first out_valid K+2 cycles after the edge sampling start; thereafter one result per cycle.
REQ-027 FLUSH->IDLE after the M-th result transfers; done pulses in that cycle; busy is 1 from the cycle after start acceptance through the done cycle.
REQ-028 start asserted while busy=1 is ignored.
REQ-029 Simultaneous transfer and new result into the output register in the same cycle is legal and loses nothing.

Reset
REQ-030 rst_n low immediately forces FSM to IDLE, clears window, skid and counters; mem_addr, mem_rd_en, out_valid, out_data, busy, done = 0.
REQ-031 Reset mid-job abandons the job; no further results or done pulse; a read response arriving after reset release is ignored.

Verification
REQ-032 K=3, weights {1,2,3}, x[i]=i+1 for i=0..7, len=8, stride=1, out_ready=1 -> out_data 14,20,26,32,38,44; first out_valid at cycle 5; done with 6th transfer.
REQ-033 Same data, stride=2 -> exactly 3 results 14,26,38 then done.
REQ-034 REQ-032 stimulus with out_ready=0 for 4 cycles after second result -> out_data held, mem_rd_en low while stalled, identical 6-value sequence.
REQ-035 len=2, start -> no out_valid, done pulse one cycle after start, busy remains 0.
REQ-036 Weights all 255, samples all 255, len=3 -> single result 64003 (195075 mod 65536).
REQ-037 rst_n low during third result, then new start -> outputs 0 during reset, new job produces full correct sequence; start pulse mid-job ignored.
